// File: rtl/debug_clkgen_if.sv
// Run-control and divided-clock bundle for debug_clkgen.
// The master drives run request and divisor; the slave returns the clock, strobes and edge count.
interface debug_clkgen_if #(
    parameter int DIV_W = 9
);
    logic             en;
    logic [DIV_W-1:0] div;
    logic             clkout;
    logic             rise;
    logic             fall;
    logic             active;
    logic [31:0]      edge_cnt;

    modport master (
        output en,
        output div,
        input  clkout,
        input  rise,
        input  fall,
        input  active,
        input  edge_cnt
    );

    modport slave (
        input  en,
        input  div,
        output clkout,
        output rise,
        output fall,
        output active,
        output edge_cnt
    );
endinterface

// File: rtl/debug_clkgen.sv
// Integer divider (P = DIV+2) with start/stop gating and registered RISE/FALL strobes.
// Optional rising-edge counter is built only when DEBUG_CLKGEN_CNT_EN is defined.
module debug_clkgen #(
    parameter int DIV_W   = 9,
    parameter int DIV_RST = 2
) (
    input  logic              clkin_i,
    input  logic              reset_i,
    debug_clkgen_if.slave     bus
);
    localparam int                CW         = DIV_W + 1;
    localparam logic [DIV_W-1:0]  DIV_RST_C  = DIV_W'(DIV_RST);
    localparam logic [CW-1:0]     CTR_ONE    = CW'(1);
    localparam logic [CW-1:0]     CTR_TWO    = CW'(2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    ctr_q, ctr_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             clkout_q, clkout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Widened by one bit so the largest period (2^DIV_W+1) never overflows.
    logic [CW-1:0] period;
    logic [CW-1:0] half;

    assign period = {1'b0, div_q} + CTR_TWO;
    assign half   = period >> 1;

    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        div_d    = div_q;
        clkout_d = clkout_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ctr_d    = '0;
                clkout_d = 1'b0;
                if (bus.en) begin
                    state_d  = ST_RUN;
                    div_d    = bus.div;
                    clkout_d = 1'b1;
                    rise_d   = 1'b1;
                end
            end

            ST_RUN: begin
                ctr_d = ctr_q + CTR_ONE;
                if (ctr_q == half - CTR_ONE) begin
                    clkout_d = 1'b0;
                    fall_d   = 1'b1;
                end
                // Divisor and run request are only honoured at the period boundary.
                if (ctr_q == period - CTR_ONE) begin
                    ctr_d = '0;
                    if (bus.en) begin
                        div_d    = bus.div;
                        clkout_d = 1'b1;
                        rise_d   = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        clkout_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                ctr_d    = '0;
                clkout_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clkin_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            ctr_q    <= '0;
            div_q    <= DIV_RST_C;
            clkout_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            div_q    <= div_d;
            clkout_q <= clkout_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign bus.clkout = clkout_q;
    assign bus.rise   = rise_q;
    assign bus.fall   = fall_q;
    assign bus.active = (state_q == ST_RUN);

`ifdef DEBUG_CLKGEN_CNT_EN
    logic [31:0] edge_cnt_q, edge_cnt_d;

    // Counts alongside the RISE strobe so EDGE_CNT already includes the edge being flagged.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (rise_d && (edge_cnt_q != 32'hFFFF_FFFF)) begin
            edge_cnt_d = edge_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clkin_i) begin
        if (reset_i) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign bus.edge_cnt = edge_cnt_q;
`else
    assign bus.edge_cnt = '0;
`endif

endmodule
